neuron_scheduler: RTL and testbench
===================================

Name: neuron_scheduler

Overview:
Round-robin scheduler that shares one Neuron activation stage between NR independent requesters, e.g. several layer or batch streams. Each requester offers a vector of NC pre-activation sums. The scheduler grants one request at a time into the Neuron, records the requester tag in an in-order tag FIFO, and steers each Neuron result back to the requester that issued it. It sits between the accumulator stages and a single shared Neuron instance.

Parameters:
NR, 2, number of requesters (>=2)
NP, 4, Neuron fan-in; sets pre-activation width
NC, 4, channels per vector
WD, 4, activation width
HIDDEN, "yes", must match the shared Neuron's HIDDEN
DEPTH, 4, tag FIFO depth (power of 2, >=2); bounds results in flight

Derived widths:
- VW = $clog2(NP)+1+WD
- OW = (HIDDEN=="yes") ? WD : VW
- TW = max(1, $clog2(NR))

Ports:
iCLK  in  1  clock
iRST  in  1  asynchronous, active-low reset
iValid_AS  in  NR  per-requester request valid
oReady_AS  out  NR  per-requester request ready
iData_AS  in  NR*NC*VW  request vectors; requester k occupies slice k*NC*VW
oValid_NS  out  1  valid toward the Neuron
iReady_NS  in  1  Neuron ready
oData_NS  out  NC*VW  granted request vector
iValid_NR  in  1  Neuron result valid
oReady_NR  out  1  result ready toward the Neuron
iData_NR  in  NC*OW  Neuron result
oValid_BS  out  NR  per-requester result valid
iReady_BS  in  NR  per-requester result ready
oData_BS  out  NC*OW  result bus, broadcast to all requesters
oTag_BS  out  TW  tag of the current head result
oErr  out  1  sticky protocol error

Behaviour:
Reset (asynchronous, iRST=0):
- Tag FIFO is emptied; rr pointer = 0; lock cleared; oErr = 0.
- All outputs are 0 while reset is held.
- A reset mid-transfer discards every tag in flight. The shared Neuron must be reset in the same cycle; this is an integration rule.

Arbitration (issue side):
- Candidate = first k with iValid_AS[k]=1, scanning from rr pointer upward and wrapping modulo NR.
- If the lock is set, the candidate is forced to the locked index.
- oValid_NS = (some request valid) && !full.
- oData_NS = slice of the candidate, muxed combinationally (zero latency).
- Issue fires when oValid_NS && iReady_NS. oReady_AS[k] = 1 only for the candidate, only when iReady_NS && !full; all other bits are 0.
- Lock: set when oValid_NS=1 and iReady_NS=0, holding the candidate so oValid_NS/oData_NS stay stable until accepted. Cleared on issue.
- On issue: push the candidate tag; rr pointer = (candidate+1) mod NR.
- When full: oValid_NS = 0 and no requester is ready. Lock, if set, is retained.

Tag FIFO:
- DEPTH entries of TW bits, with wr/rd pointers and a count 0..DEPTH.
- Full means count==DEPTH; a push is blocked even if a pop occurs in the same cycle.
- Simultaneous push and pop while non-full: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.

Return side:
- h = head tag; oTag_BS = h (0 when empty).
- oValid_BS[h] = iValid_NR && !empty; other bits are 0.
- oReady_NR = !empty && iReady_BS[h].
- oData_BS = iData_NR, passed through combinationally.
- Pop on iValid_NR && oReady_NR.

Error:
- iValid_NR=1 while the FIFO is empty sets oErr=1. It clears only on reset.
- In that case oReady_NR=0 and no oValid_BS is raised.

Other:
- Ordering: results return strictly in issue order. The Neuron is an in-order 1-deep stage, so no reordering occurs.
- Throughput: one issue and one return per cycle; no bubbles while not full and downstream is ready.

Decomposition:
- Package neuron_pkg holds functions and constants VW(NP,WD), OW(HIDDEN,NP,WD) and TW(NR), shared with Neuron and the accumulator stages.
- Sub-module tag_fifo (params WIDTH=TW, DEPTH) provides push, pop, full, empty and head, with asynchronous active-low reset.
- The round-robin pick stays inline as a combinational function.

Test Plan:
1. Reset with iValid_AS=2'b11 held -> after release the first grant goes to k=0 (oReady_AS=01), the next cycle to k=1 (10), alternating every cycle with iReady_NS=1.
2. iValid_AS=2'b10 only, iReady_NS=0 for 3 cycles -> oValid_NS stays 1 and oData_NS stays the k=1 slice. On the fourth cycle (iReady_NS=1) oReady_AS=10; an issue from k=0 asserted meanwhile does not preempt.
3. DEPTH=4, hold iValid_NR=0 and issue 4 vectors -> oValid_NS=0 and oReady_AS=00 on the fifth. One pop restores issue on the following cycle only.
4. Issue k=0 then k=1; Neuron returns r0, r1; iReady_BS=2'b01 -> r0 goes out on oValid_BS=01 with oTag_BS=0. r1 stalls (oReady_NR=0) until iReady_BS[1]=1, then oValid_BS=10.
5. Assert iValid_NR with the FIFO empty -> oErr=1 the next cycle, and it stays 1 across later traffic until iRST=0.
6. Assert iRST=0 asynchronously with 3 tags in flight -> all outputs 0 immediately. After release count=0, rr pointer=0 and the first grant goes to k=0.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared widths and types for the Neuron datapath: the accumulator stages,
// the Neuron itself and the scheduler all size their buses from here.
package neuron_pkg;

  // The issue side is either free to re-arbitrate or locked on a pending
  // offer until the Neuron accepts it.
  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } issue_state_t;

  // Pre-activation sum width for a Neuron of fan-in np and activation width wd.
  function automatic int vw(input int np, input int wd);
    return $clog2(np) + 1 + wd;
  endfunction

  // Result width: hidden neurons emit activations, output neurons emit raw sums.
  function automatic int ow(input bit hidden, input int np, input int wd);
    return hidden ? wd : vw(np, wd);
  endfunction

  // Requester tag width, never narrower than one bit.
  function automatic int tw(input int nr);
    return (nr > 1) ? $clog2(nr) : 1;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of requester tags; one entry per vector in flight in the Neuron.
module tag_fifo
  import neuron_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage needs no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/neuron_scheduler.sv
// Round-robin sharing of one Neuron stage between NR requesters, with an
// in-order tag FIFO steering each result back to the requester that issued it.
module neuron_scheduler
  import neuron_pkg::*;
#(
  parameter int NR     = 2,
  parameter int NP     = 4,
  parameter int NC     = 4,
  parameter int WD     = 4,
  parameter     HIDDEN = "yes",
  parameter int DEPTH  = 4,
  localparam int VW    = vw(NP, WD),
  localparam int OW    = ow(HIDDEN == "yes", NP, WD),
  localparam int TW    = tw(NR)
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [NR-1:0]      iValid_AS,
  output logic [NR-1:0]      oReady_AS,
  input  logic [NR*NC*VW-1:0] iData_AS,
  output logic               oValid_NS,
  input  logic               iReady_NS,
  output logic [NC*VW-1:0]   oData_NS,
  input  logic               iValid_NR,
  output logic               oReady_NR,
  input  logic [NC*OW-1:0]   iData_NR,
  output logic [NR-1:0]      oValid_BS,
  input  logic [NR-1:0]      iReady_BS,
  output logic [NC*OW-1:0]   oData_BS,
  output logic [TW-1:0]      oTag_BS,
  output logic               oErr
);

  issue_state_t      state_q, state_d;
  logic [TW-1:0]     lock_idx_q, lock_idx_d;
  logic [TW-1:0]     rr_q, rr_d;
  logic [TW-1:0]     cand;
  logic [TW-1:0]     head;
  logic [TW-1:0]     tag;
  logic [NR-1:0]     ready_as;
  logic [NR-1:0]     valid_bs;
  logic [NC*VW-1:0]  data_ns;
  logic              valid_ns;
  logic              issue;
  logic              full;
  logic              empty;
  logic              ready_nr;
  logic              pop;
  logic              err_q;

  // First valid requester at or after ptr, wrapping; scanning downward lets
  // the smallest offset from ptr win.
  function automatic logic [TW-1:0] rr_pick(input logic [NR-1:0] req,
                                            input logic [TW-1:0] ptr);
    logic [TW-1:0] pick;
    int            j;
    pick = ptr;
    for (int i = NR-1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NR;
      if (req[j]) pick = TW'(j);
    end
    return pick;
  endfunction

  // Issue-side arbitration, lock handling and round-robin pointer advance.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    ready_as   = '0;
    cand       = (state_q == ST_LOCKED) ? lock_idx_q : rr_pick(iValid_AS, rr_q);
    valid_ns   = (|iValid_AS) && !full;
    issue      = valid_ns && iReady_NS;
    if (iReady_NS && !full) ready_as[cand] = 1'b1;
    case (state_q)
      ST_FREE: begin
        if (valid_ns && !iReady_NS) begin
          state_d    = ST_LOCKED;
          lock_idx_d = cand;
        end
      end
      ST_LOCKED: begin
        if (issue) state_d = ST_FREE;
      end
      default: state_d = ST_FREE;
    endcase
    if (issue) rr_d = (int'(cand) == NR-1) ? '0 : cand + 1'b1;
  end

  // The granted vector is muxed straight through to the Neuron.
  assign data_ns = iData_AS[int'(cand)*NC*VW +: NC*VW];

  // Issue-side state registers.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q    <= ST_FREE;
      lock_idx_q <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
    end
  end

  tag_fifo #(
    .WIDTH (TW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (iCLK),
    .rst_n (iRST),
    .push  (issue),
    .pop   (pop),
    .din   (cand),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Return-side steering by the head tag; nothing is accepted while empty.
  always_comb begin
    tag      = empty ? '0 : head;
    valid_bs = '0;
    if (iValid_NR && !empty) valid_bs[head] = 1'b1;
    ready_nr = !empty && iReady_BS[head];
    pop      = iValid_NR && ready_nr;
  end

  // A Neuron result with no tag in flight is a protocol error held until reset.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      err_q <= 1'b0;
    end else if (iValid_NR && empty) begin
      err_q <= 1'b1;
    end
  end

  // Outputs are forced low while reset is held, including the pass-through paths.
  assign oValid_NS = iRST & valid_ns;
  assign oReady_AS = iRST ? ready_as : '0;
  assign oData_NS  = iRST ? data_ns : '0;
  assign oReady_NR = iRST & ready_nr;
  assign oValid_BS = iRST ? valid_bs : '0;
  assign oData_BS  = iRST ? iData_NR : '0;
  assign oTag_BS   = iRST ? tag : '0;
  assign oErr      = err_q;

endmodule

// File: tb/tb_neuron_scheduler.sv
// Scoreboard bench for neuron_scheduler: stimulus pushes expected issues and
// returns, two monitors pop and compare whenever the DUT completes a transfer.
module tb_neuron_scheduler;

  localparam int NR = 2, NP = 4, NC = 4, WD = 4, DEPTH = 4;
  localparam int VW = 7, OW = 4, TW = 1;
  localparam logic [NC*VW-1:0] REQ0 = 28'h0A1B2C3;
  localparam logic [NC*VW-1:0] REQ1 = 28'h5D4E6F7;

  typedef struct packed {
    logic [NR-1:0]    grant;
    logic [NC*VW-1:0] data;
  } iss_t;

  typedef struct packed {
    logic [TW-1:0]    tag;
    logic [NC*OW-1:0] data;
  } ret_t;

  logic                iCLK = 1'b0;
  logic                iRST;
  logic [NR-1:0]       iValid_AS;
  logic [NR-1:0]       oReady_AS;
  logic [NR*NC*VW-1:0] iData_AS;
  logic                oValid_NS;
  logic                iReady_NS;
  logic [NC*VW-1:0]    oData_NS;
  logic                iValid_NR;
  logic                oReady_NR;
  logic [NC*OW-1:0]    iData_NR;
  logic [NR-1:0]       oValid_BS;
  logic [NR-1:0]       iReady_BS;
  logic [NC*OW-1:0]    oData_BS;
  logic [TW-1:0]       oTag_BS;
  logic                oErr;

  iss_t iss_q[$];
  ret_t ret_q[$];
  iss_t iss_e;
  ret_t ret_e;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 iCLK = ~iCLK;

  assign iData_AS = {REQ1, REQ0};

  neuron_scheduler #(
    .NR(NR), .NP(NP), .NC(NC), .WD(WD), .HIDDEN("yes"), .DEPTH(DEPTH)
  ) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iValid_AS(iValid_AS), .oReady_AS(oReady_AS), .iData_AS(iData_AS),
    .oValid_NS(oValid_NS), .iReady_NS(iReady_NS), .oData_NS(oData_NS),
    .iValid_NR(iValid_NR), .oReady_NR(oReady_NR), .iData_NR(iData_NR),
    .oValid_BS(oValid_BS), .iReady_BS(iReady_BS), .oData_BS(oData_BS),
    .oTag_BS(oTag_BS), .oErr(oErr)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [NR-1:0] valid_as, input logic ready_ns,
                                input logic valid_nr, input logic [NC*OW-1:0] data_nr,
                                input logic [NR-1:0] ready_bs);
    iValid_AS = valid_as;
    iReady_NS = ready_ns;
    iValid_NR = valid_nr;
    iData_NR  = data_nr;
    iReady_BS = ready_bs;
  endtask

  task automatic next_cycle();
    @(posedge iCLK);
    #1;
  endtask

  task automatic push_iss(input logic [NR-1:0] grant, input logic [NC*VW-1:0] data);
    iss_t e;
    e.grant = grant;
    e.data  = data;
    iss_q.push_back(e);
  endtask

  task automatic push_ret(input logic [TW-1:0] tag, input logic [NC*OW-1:0] data);
    ret_t e;
    e.tag  = tag;
    e.data = data;
    ret_q.push_back(e);
  endtask

  // Issue monitor: every accepted offer must match the next expected grant.
  always @(negedge iCLK) begin
    if (iRST && oValid_NS && iReady_NS) begin
      if (iss_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_issue: got grant %0h, expected none", oReady_AS);
      end else begin
        iss_e = iss_q.pop_front();
        check_output("issue_grant", 64'(oReady_AS), 64'(iss_e.grant));
        check_output("issue_data", 64'(oData_NS), 64'(iss_e.data));
      end
    end
  end

  // Return monitor: every accepted result must go to the expected requester.
  always @(negedge iCLK) begin
    if (iRST && iValid_NR && oReady_NR) begin
      if (ret_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_return: got tag %0h, expected none", oTag_BS);
      end else begin
        ret_e = ret_q.pop_front();
        check_output("return_tag", 64'(oTag_BS), 64'(ret_e.tag));
        check_output("return_valid", 64'(oValid_BS), 64'(NR'(1) << ret_e.tag));
        check_output("return_data", 64'(oData_BS), 64'(ret_e.data));
      end
    end
  end

  initial begin
    iRST = 1'b0;
    apply_stimulus(2'b11, 1'b1, 1'b1, 16'hBEEF, 2'b11);
    @(negedge iCLK);
    check_output("rst_valid_ns", 64'(oValid_NS), 64'(0));
    check_output("rst_ready_as", 64'(oReady_AS), 64'(0));
    check_output("rst_data_ns", 64'(oData_NS), 64'(0));
    check_output("rst_ready_nr", 64'(oReady_NR), 64'(0));
    check_output("rst_valid_bs", 64'(oValid_BS), 64'(0));
    check_output("rst_data_bs", 64'(oData_BS), 64'(0));
    check_output("rst_err", 64'(oErr), 64'(0));
    next_cycle();

    // Both requesters valid: grants alternate 0,1,0,1 and fill the FIFO.
    iRST = 1'b1;
    apply_stimulus(2'b11, 1'b1, 1'b0, 16'h0000, 2'b11);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_iss(2'b01, REQ0);
      else            push_iss(2'b10, REQ1);
      @(negedge iCLK);
      check_output("rr_ready_as", 64'(oReady_AS), (i % 2 == 0) ? 64'h1 : 64'h2);
      next_cycle();
    end

    // Full: no offer, no requester ready.
    @(negedge iCLK);
    check_output("full_valid_ns", 64'(oValid_NS), 64'(0));
    check_output("full_ready_as", 64'(oReady_AS), 64'(0));
    next_cycle();

    // One pop: issue stays blocked in the popping cycle, resumes next cycle.
    apply_stimulus(2'b11, 1'b1, 1'b1, 16'hA0A0, 2'b11);
    push_ret(1'b0, 16'hA0A0);
    @(negedge iCLK);
    check_output("pop_cycle_valid_ns", 64'(oValid_NS), 64'(0));
    next_cycle();
    apply_stimulus(2'b11, 1'b1, 1'b0, 16'h0000, 2'b11);
    push_iss(2'b01, REQ0);
    @(negedge iCLK);
    check_output("after_pop_valid_ns", 64'(oValid_NS), 64'(1));
    next_cycle();

    // Drain the four tags 1,0,1,0 in issue order.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(2'b00, 1'b1, 1'b1, 16'(16'hB000 + i), 2'b11);
      push_ret((i % 2 == 0) ? 1'b1 : 1'b0, 16'(16'hB000 + i));
      next_cycle();
    end

    // Single issue from requester 1 brings the pointer back to 0.
    apply_stimulus(2'b10, 1'b1, 1'b0, 16'h0000, 2'b11);
    push_iss(2'b10, REQ1);
    next_cycle();

    // Lock: requester 1 stalled three cycles; requester 0 arriving must not preempt.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus((i == 0) ? 2'b10 : 2'b11, 1'b0, 1'b0, 16'h0000, 2'b11);
      @(negedge iCLK);
      check_output("lock_valid_ns", 64'(oValid_NS), 64'(1));
      check_output("lock_data_ns", 64'(oData_NS), 64'(REQ1));
      check_output("lock_ready_as", 64'(oReady_AS), 64'(0));
      next_cycle();
    end
    apply_stimulus(2'b11, 1'b1, 1'b0, 16'h0000, 2'b11);
    push_iss(2'b10, REQ1);
    @(negedge iCLK);
    check_output("lock_release_ready_as", 64'(oReady_AS), 64'(2'b10));
    next_cycle();

    // Drain the two requester-1 tags, then issue 0 and 1 for the steering test.
    apply_stimulus(2'b00, 1'b1, 1'b1, 16'hC001, 2'b11);
    push_ret(1'b1, 16'hC001);
    next_cycle();
    apply_stimulus(2'b00, 1'b1, 1'b1, 16'hC002, 2'b11);
    push_ret(1'b1, 16'hC002);
    next_cycle();
    apply_stimulus(2'b11, 1'b1, 1'b0, 16'h0000, 2'b11);
    push_iss(2'b01, REQ0);
    next_cycle();
    push_iss(2'b10, REQ1);
    next_cycle();

    // Return steering: r0 goes out, r1 stalls until requester 1 is ready.
    apply_stimulus(2'b00, 1'b1, 1'b1, 16'hD000, 2'b01);
    push_ret(1'b0, 16'hD000);
    @(negedge iCLK);
    check_output("steer_r0_valid_bs", 64'(oValid_BS), 64'(2'b01));
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(2'b00, 1'b1, 1'b1, 16'hD111, 2'b01);
      @(negedge iCLK);
      check_output("stall_valid_bs", 64'(oValid_BS), 64'(2'b10));
      check_output("stall_ready_nr", 64'(oReady_NR), 64'(0));
      check_output("stall_tag", 64'(oTag_BS), 64'(1));
      next_cycle();
    end
    apply_stimulus(2'b00, 1'b1, 1'b1, 16'hD111, 2'b11);
    push_ret(1'b1, 16'hD111);
    next_cycle();

    // Protocol error: result while empty is refused and sets the sticky flag.
    apply_stimulus(2'b00, 1'b1, 1'b1, 16'hE0E0, 2'b11);
    @(negedge iCLK);
    check_output("err_ready_nr", 64'(oReady_NR), 64'(0));
    check_output("err_valid_bs", 64'(oValid_BS), 64'(0));
    check_output("err_not_yet", 64'(oErr), 64'(0));
    next_cycle();
    apply_stimulus(2'b00, 1'b1, 1'b0, 16'h0000, 2'b11);
    @(negedge iCLK);
    check_output("err_set", 64'(oErr), 64'(1));
    next_cycle();

    // Three issues in flight (error must persist), then asynchronous reset.
    apply_stimulus(2'b11, 1'b1, 1'b0, 16'h0000, 2'b11);
    for (int i = 0; i < 3; i++) begin
      if (i % 2 == 0) push_iss(2'b01, REQ0);
      else            push_iss(2'b10, REQ1);
      @(negedge iCLK);
      check_output("err_sticky", 64'(oErr), 64'(1));
      next_cycle();
    end
    #2;
    iRST = 1'b0;
    iValid_NR = 1'b1;
    iData_NR = 16'hF0F0;
    #1;
    check_output("async_rst_valid_ns", 64'(oValid_NS), 64'(0));
    check_output("async_rst_ready_as", 64'(oReady_AS), 64'(0));
    check_output("async_rst_data_ns", 64'(oData_NS), 64'(0));
    check_output("async_rst_valid_bs", 64'(oValid_BS), 64'(0));
    check_output("async_rst_ready_nr", 64'(oReady_NR), 64'(0));
    check_output("async_rst_data_bs", 64'(oData_BS), 64'(0));
    check_output("async_rst_err", 64'(oErr), 64'(0));
    iss_q.delete();
    ret_q.delete();
    next_cycle();

    // After release: FIFO empty, pointer back at 0.
    iRST = 1'b1;
    apply_stimulus(2'b11, 1'b1, 1'b0, 16'h0000, 2'b11);
    push_iss(2'b01, REQ0);
    @(negedge iCLK);
    check_output("post_rst_ready_as", 64'(oReady_AS), 64'(2'b01));
    check_output("post_rst_empty", 64'(oReady_NR), 64'(0));
    check_output("post_rst_err", 64'(oErr), 64'(0));
    next_cycle();
    push_iss(2'b10, REQ1);
    next_cycle();
    apply_stimulus(2'b00, 1'b1, 1'b1, 16'h1234, 2'b11);
    push_ret(1'b0, 16'h1234);
    next_cycle();
    apply_stimulus(2'b00, 1'b1, 1'b1, 16'h5678, 2'b11);
    push_ret(1'b1, 16'h5678);
    next_cycle();
    apply_stimulus(2'b00, 1'b1, 1'b0, 16'h0000, 2'b11);
    next_cycle();

    check_output("issue_queue_drained", 64'(iss_q.size()), 64'(0));
    check_output("return_queue_drained", 64'(ret_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
